// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: Decode/Execute/Memory status in, stall/flush controls and perf counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             dec_valid_i;
    logic [4:0]       dec_rs1_addr_i;
    logic [4:0]       dec_rs2_addr_i;
    logic             dec_uses_rs1_i;
    logic             dec_uses_rs2_i;
    logic [4:0]       ex_rd_addr_i;
    logic             ex_rd_wr_i;
    logic             ex_is_load_i;
    logic             ex_br_taken_i;
    logic             mem_busy_i;
    logic             cnt_clr_i;
    logic             stall_ftch_o;
    logic             stall_dec_o;
    logic             stall_ex_o;
    logic             bubble_dec_o;
    logic             flush_ftch_o;
    logic             mem_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    // Core side: reports pipeline status, consumes controls
    modport master (
        output dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_uses_rs1_i, dec_uses_rs2_i,
        output ex_rd_addr_i, ex_rd_wr_i, ex_is_load_i, ex_br_taken_i, mem_busy_i, cnt_clr_i,
        input  stall_ftch_o, stall_dec_o, stall_ex_o, bubble_dec_o, flush_ftch_o,
        input  mem_timeout_o, stall_cnt_o, flush_cnt_o
    );

    // Controller side
    modport slave (
        input  dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_uses_rs1_i, dec_uses_rs2_i,
        input  ex_rd_addr_i, ex_rd_wr_i, ex_is_load_i, ex_br_taken_i, mem_busy_i, cnt_clr_i,
        output stall_ftch_o, stall_dec_o, stall_ex_o, bubble_dec_o, flush_ftch_o,
        output mem_timeout_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage core: mem wait > taken branch > load-use,
// with saturating stall/flush cycle counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_MEM_WAIT = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int unsigned FR_W   = 2;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, MEMWAIT} state_e;

    state_e            state_q, state_d;
    logic [FR_W-1:0]   flush_rem_q, flush_rem_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic stall_all, stall_f, bubble, flush, timeout, any_stall;

    always_comb begin
        load_use = hz.dec_valid_i & hz.ex_is_load_i & hz.ex_rd_wr_i & (hz.ex_rd_addr_i != 5'd0) &
                   ((hz.dec_uses_rs1_i & (hz.dec_rs1_addr_i == hz.ex_rd_addr_i)) |
                    (hz.dec_uses_rs2_i & (hz.dec_rs2_addr_i == hz.ex_rd_addr_i)));
    end

    // Next state and same-cycle control outputs
    always_comb begin
        state_d     = state_q;
        flush_rem_d = flush_rem_q;
        wait_cnt_d  = wait_cnt_q;
        stall_all   = 1'b0;
        stall_f     = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        timeout     = 1'b0;
        if (state_q == MEMWAIT) begin
            if (!hz.mem_busy_i) begin
                state_d    = (flush_rem_q != '0) ? FLUSH : RUN;
                wait_cnt_d = '0;
            end else if ((9'({1'b0, wait_cnt_q}) + 9'd1) >= 9'(MAX_MEM_WAIT)) begin
                timeout    = 1'b1;
                state_d    = (flush_rem_q != '0) ? FLUSH : RUN;
                wait_cnt_d = '0;
            end else begin
                stall_all  = 1'b1;
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else if (hz.mem_busy_i) begin
            stall_all  = 1'b1;
            wait_cnt_d = WAIT_W'(1);
            state_d    = MEMWAIT;
        end else if (hz.ex_br_taken_i) begin
            flush       = 1'b1;
            bubble      = 1'b1;
            flush_rem_d = FR_W'(FLUSH_CYCLES - 1);
            state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
            flush       = 1'b1;
            bubble      = 1'b1;
            flush_rem_d = flush_rem_q - FR_W'(1);
            state_d     = (flush_rem_q == FR_W'(1)) ? RUN : FLUSH;
        end else if ((state_q == RUN) && load_use) begin
            stall_f = 1'b1;
            bubble  = 1'b1;
            state_d = LDSTALL;
        end else begin
            state_d = RUN;
        end
    end

    assign any_stall = stall_all | stall_f;

    // Saturating perf counters; clear wins over increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (any_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush && !(&flush_cnt_q))     flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            flush_rem_q <= '0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_rem_q <= flush_rem_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are forced low while reset is asserted, independent of the clock
    assign hz.stall_ftch_o  = rst_ni & any_stall;
    assign hz.stall_dec_o   = rst_ni & stall_all;
    assign hz.stall_ex_o    = rst_ni & stall_all;
    assign hz.bubble_dec_o  = rst_ni & bubble;
    assign hz.flush_ftch_o  = rst_ni & flush;
    assign hz.mem_timeout_o = rst_ni & timeout;
    assign hz.stall_cnt_o   = stall_cnt_q;
    assign hz.flush_cnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl: cycle-level behavioural model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned FC   = 2;
    localparam int unsigned MW   = 8;
    localparam int unsigned CW   = 8;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz();

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_MEM_WAIT(MW), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining flush cycles, length of current busy run, wait flag
    int flush_left = 0;
    int busy_run   = 0;
    bit in_wait    = 0;
    bit ld_done    = 0;
    int m_stall    = 0;
    int m_flush    = 0;

    always @(negedge clk) begin
        logic [5:0] e;
        logic       lu;
        if (!rst_n) begin
            chk("rst_ctrl", {hz.stall_ftch_o, hz.stall_dec_o, hz.stall_ex_o, hz.bubble_dec_o,
                             hz.flush_ftch_o, hz.mem_timeout_o}, 32'd0);
            chk("rst_cnt", {hz.stall_cnt_o, hz.flush_cnt_o}, 32'd0);
            flush_left = 0; busy_run = 0; in_wait = 0; ld_done = 0; m_stall = 0; m_flush = 0;
        end else begin
            lu = hz.dec_valid_i && hz.ex_is_load_i && hz.ex_rd_wr_i && hz.ex_rd_addr_i != 0 &&
                 ((hz.dec_uses_rs1_i && hz.dec_rs1_addr_i == hz.ex_rd_addr_i) ||
                  (hz.dec_uses_rs2_i && hz.dec_rs2_addr_i == hz.ex_rd_addr_i));
            e = '0; // {stall_f, stall_d, stall_e, bubble, flush, timeout}
            if (in_wait) begin
                ld_done = 0;
                if (!hz.mem_busy_i) begin
                    in_wait = 0; busy_run = 0;
                end else if (busy_run + 1 >= int'(MW)) begin
                    e[0] = 1'b1; in_wait = 0; busy_run = 0;
                end else begin
                    e[5:3] = 3'b111; busy_run++;
                end
            end else if (hz.mem_busy_i) begin
                e[5:3] = 3'b111; in_wait = 1; busy_run = 1; ld_done = 0;
            end else if (hz.ex_br_taken_i) begin
                e[2:1] = 2'b11; flush_left = int'(FC) - 1; ld_done = 0;
            end else if (flush_left > 0) begin
                e[2:1] = 2'b11; flush_left--; ld_done = 0;
            end else if (lu && !ld_done) begin
                e[5] = 1'b1; e[2] = 1'b1; ld_done = 1;
            end else begin
                ld_done = 0;
            end
            chk("ctrl", {hz.stall_ftch_o, hz.stall_dec_o, hz.stall_ex_o, hz.bubble_dec_o,
                         hz.flush_ftch_o, hz.mem_timeout_o}, 32'(e));
            chk("stall_cnt", 32'(hz.stall_cnt_o), 32'(m_stall));
            chk("flush_cnt", 32'(hz.flush_cnt_o), 32'(m_flush));
            if (hz.cnt_clr_i) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (e[5:3] != 0 && m_stall < CMAX) m_stall++;
                if (e[1] && m_flush < CMAX) m_flush++;
            end
        end
    end

    task automatic idle();
        hz.dec_valid_i = 0; hz.dec_rs1_addr_i = 0; hz.dec_rs2_addr_i = 0;
        hz.dec_uses_rs1_i = 0; hz.dec_uses_rs2_i = 0; hz.ex_rd_addr_i = 0;
        hz.ex_rd_wr_i = 0; hz.ex_is_load_i = 0; hz.ex_br_taken_i = 0;
        hz.mem_busy_i = 0; hz.cnt_clr_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Load-use: LW x5 in EX, ADD x6,x5,x7 in Decode
        step();
        hz.dec_valid_i = 1; hz.dec_rs1_addr_i = 5; hz.dec_rs2_addr_i = 7;
        hz.dec_uses_rs1_i = 1; hz.dec_uses_rs2_i = 1;
        hz.ex_rd_addr_i = 5; hz.ex_rd_wr_i = 1; hz.ex_is_load_i = 1;
        #2 chk("lu_stall", {hz.stall_ftch_o, hz.bubble_dec_o, hz.stall_dec_o}, 32'b110);
        step();
        #2 chk("lu_once", {hz.stall_ftch_o, hz.bubble_dec_o, hz.stall_dec_o}, 32'b000);
        step(); idle();
        #2 chk("lu_cnt", 32'(hz.stall_cnt_o), 32'd1);

        // Load to x0 never hazards
        step();
        hz.dec_valid_i = 1; hz.dec_rs1_addr_i = 0; hz.dec_uses_rs1_i = 1;
        hz.ex_rd_addr_i = 0; hz.ex_rd_wr_i = 1; hz.ex_is_load_i = 1;
        #2 chk("x0_nohaz", {hz.stall_ftch_o, hz.bubble_dec_o}, 32'b00);

        // Taken branch, two flush cycles
        step(); idle(); hz.ex_br_taken_i = 1;
        #2 chk("br_c1", {hz.flush_ftch_o, hz.bubble_dec_o}, 32'b11);
        step(); hz.ex_br_taken_i = 0;
        #2 chk("br_c2", {hz.flush_ftch_o, hz.bubble_dec_o}, 32'b11);
        step();
        #2 chk("br_done", 32'(hz.flush_ftch_o), 32'd0);
        chk("br_cnt", 32'(hz.flush_cnt_o), 32'd2);

        // Mem busy during FLUSH: full stalls, then flush resumes
        step(); hz.ex_br_taken_i = 1;
        step(); hz.ex_br_taken_i = 0; hz.mem_busy_i = 1;
        #2 chk("fl_busy", {hz.stall_ftch_o, hz.stall_dec_o, hz.stall_ex_o, hz.flush_ftch_o}, 32'b1110);
        repeat (3) step();
        step(); hz.mem_busy_i = 0;
        repeat (3) step();

        // Stuck mem_busy: timeout pulse on the 8th cycle
        for (int i = 1; i <= 8; i++) begin
            step(); hz.mem_busy_i = 1;
            #2 chk("to_pulse", {hz.mem_timeout_o, hz.stall_ex_o}, (i == 8) ? 32'b10 : 32'b01);
        end
        step(); hz.mem_busy_i = 0;

        // Async reset inside MEMWAIT
        step(); hz.mem_busy_i = 1;
        step();
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {hz.stall_ftch_o, hz.stall_dec_o, hz.stall_ex_o, hz.mem_timeout_o}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Counter saturation and clear
        repeat (320) step();
        #2 chk("sat_ff", 32'(hz.stall_cnt_o), 32'(CMAX));
        step();
        #2 chk("sat_hold", 32'(hz.stall_cnt_o), 32'(CMAX));
        step(); hz.mem_busy_i = 0; hz.cnt_clr_i = 1;
        step(); hz.cnt_clr_i = 0;
        #2 chk("clr_zero", {hz.stall_cnt_o, hz.flush_cnt_o}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            hz.dec_valid_i    = ($urandom_range(0, 9) < 8);
            hz.dec_rs1_addr_i = 5'($urandom_range(0, 3));
            hz.dec_rs2_addr_i = 5'($urandom_range(0, 3));
            hz.dec_uses_rs1_i = 1'($urandom_range(0, 1));
            hz.dec_uses_rs2_i = 1'($urandom_range(0, 1));
            hz.ex_rd_addr_i   = 5'($urandom_range(0, 3));
            hz.ex_rd_wr_i     = ($urandom_range(0, 9) < 8);
            hz.ex_is_load_i   = ($urandom_range(0, 9) < 5);
            hz.ex_br_taken_i  = ($urandom_range(0, 99) < 10);
            hz.mem_busy_i     = (i % 400 > 380) ? 1'b1 : ($urandom_range(0, 99) < 12);
            hz.cnt_clr_i      = ($urandom_range(0, 99) < 2);
            rst_n             = (i != 1500);
        end
        step(); idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
